// File: rtl/rf_pkg.sv
// Register-file constants shared by the write-back path and its users.
package rf_pkg;

  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 32;

  localparam logic [RF_AW-1:0] RF_ZERO_ADDR = '0;

  // One-hot decode of a register address, used for hazard masks.
  function automatic logic [RF_DEPTH-1:0] onehot_addr(input logic [RF_AW-1:0] addr);
    logic [RF_DEPTH-1:0] m;
    m       = '0;
    m[addr] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first asserted request at or after ptr (wrapping)
// wins. Pure combinational; the caller owns the pointer.
module rr_arbiter #(
  parameter int N = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // Scan N positions starting at ptr and take the first active request.
  always_comb begin
    int          idx;
    logic        found;
    logic [PW-1:0] pos;
    // NOTE: every output and temporary gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    pos     = '0;
    if (en) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        pos = PW'(idx);
        if (!found && req[pos]) begin
          gnt[pos] = 1'b1;
          gnt_idx  = pos;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the register-file write port between NREQ
// requesters through a round-robin grant and a one-stage write buffer.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int CW   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_en,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                rf_we,
  output logic [AW-1:0]       rf_wa,
  output logic [DW-1:0]       rf_wd,
  output logic [2**AW-1:0]    pend_mask,
  output logic [CW-1:0]       cont_cnt,
  input  logic                cont_clr
);

  localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int DEPTH = 2**AW;

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          xfer;
  logic          contention;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .en      (wb_en),
    .gnt     (req_ready),
    .gnt_idx (gnt_idx)
  );

  assign xfer       = |(req_valid & req_ready);
  assign contention = wb_en && ($countones(req_valid) >= 2);

  // One-hot AND-OR mux of the granted requester's address and data.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = sel_addr | req_addr[i*AW +: AW];
        sel_data = sel_data | req_data[i*DW +: DW];
      end
    end
  end

  // Write buffer: capture the winner; x0 writes complete the handshake but
  // never raise the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the address/data buffer is reset along with the enable so the
    // register-file port shows defined values straight out of reset.
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else if (xfer) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      rf_we <= (sel_addr != AW'(RF_ZERO_ADDR));
      rf_wa <= sel_addr;
      rf_wd <= sel_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Round-robin pointer: moves just past the winner after each transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Saturating contention counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cont_cnt <= '0;
    end else if (cont_clr) begin
      cont_cnt <= '0;
    end else if (contention && (cont_cnt != {CW{1'b1}})) begin
      cont_cnt <= cont_cnt + 1'b1;
    end
  end

  // Pending-write mask decoded only from registered state.
  generate
    if (AW == RF_AW) begin : g_pend_rf
      assign pend_mask = rf_we ? onehot_addr(rf_wa) : '0;
    end else begin : g_pend_generic
      assign pend_mask = rf_we ? ({{(DEPTH-1){1'b0}}, 1'b1} << rf_wa) : '0;
    end
  endgenerate

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic wb_en    = 1'b0;
  logic cont_clr = 1'b0;
  logic [NREQ-1:0] req_valid = '0;
  logic [AW-1:0]   a_addr [NREQ];
  logic [DW-1:0]   a_data [NREQ];
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;

  logic [NREQ-1:0]  req_ready, req_ready4;
  logic             rf_we, rf_we4;
  logic [AW-1:0]    rf_wa, rf_wa4;
  logic [DW-1:0]    rf_wd, rf_wd4;
  logic [2**AW-1:0] pend_mask, pend_mask4;
  logic [15:0]      cont_cnt;
  logic [3:0]       cont_cnt4;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW] = a_addr[i];
      req_data[i*DW +: DW] = a_data[i];
    end
  end

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pend_mask(pend_mask),
    .cont_cnt(cont_cnt), .cont_clr(cont_clr)
  );

  rf_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb_en(wb_en), .req_valid(req_valid),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready4),
    .rf_we(rf_we4), .rf_wa(rf_wa4), .rf_wd(rf_wd4), .pend_mask(pend_mask4),
    .cont_cnt(cont_cnt4), .cont_clr(cont_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_ptr;
  bit          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  int          m_cnt;
  int          m_cnt4;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 0; m_wa = '0; m_wd = '0; m_cnt = 0; m_cnt4 = 0;
  endtask

  // Grant rule: first valid index searching from ptr, wrapping modulo NREQ.
  function automatic int model_grant();
    if (!wb_en) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outputs();
    check("rf_we", rf_we, m_we);
    check("rf_wa", rf_wa, m_wa);
    check("rf_wd", rf_wd, m_wd);
    check("pend_mask", pend_mask, m_we ? (64'd1 << m_wa) : 64'd0);
    check("cont_cnt", cont_cnt, m_cnt);
    check("cont_cnt4", cont_cnt4, m_cnt4);
  endtask

  // One clock: check the combinational grant, advance the model, then check
  // the registered outputs just after the edge.
  task automatic cycle();
    int g;
    int nv;
    #1;
    g  = model_grant();
    nv = $countones(req_valid);
    check("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
    if (g >= 0) begin
      m_wa  = a_addr[g];
      m_wd  = a_data[g];
      m_we  = (a_addr[g] != 0);
      m_ptr = (g + 1) % NREQ;
    end else begin
      m_we = 0;
    end
    if (cont_clr) begin
      m_cnt = 0; m_cnt4 = 0;
    end else if (wb_en && nv >= 2) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    int saved;
    for (int i = 0; i < NREQ; i++) begin
      a_addr[i] = '0;
      a_data[i] = '0;
    end
    model_reset();

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    check("rst_ready", req_ready, 0);
    check_outputs();
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin with all requesters valid
    wb_en = 1'b1;
    req_valid = 3'b111;
    for (int i = 0; i < NREQ; i++) begin
      a_addr[i] = AW'(i + 1);
      a_data[i] = 32'hA000_0000 + DW'(i);
    end
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_grant", req_ready, 64'd1 << (i % 3));
      cycle();
      check("rr_wa", rf_wa, (i % 3) + 1);
    end
    check("rr_cnt", cont_cnt, 6);

    // Single request (ptr is back at 0)
    req_valid = 3'b001;
    a_addr[0] = 5'd5;
    a_data[0] = 32'hDEADBEEF;
    #1 check("single_ready", req_ready, 3'b001);
    cycle();
    check("single_we", rf_we, 1);
    check("single_wa", rf_wa, 5);
    check("single_wd", rf_wd, 32'hDEADBEEF);
    check("single_pend", pend_mask, 32'h0000_0020);
    req_valid = 3'b000;
    cycle();
    check("single_we_drop", rf_we, 0);

    // x0 write: handshake completes, no register-file write
    req_valid = 3'b010;
    a_addr[1] = 5'd0;
    a_data[1] = 32'h1234;
    #1 check("x0_ready", req_ready, 3'b010);
    cycle();
    check("x0_we", rf_we, 0);
    check("x0_pend", pend_mask, 0);
    a_addr[1] = 5'd2;
    req_valid = 3'b111;
    #1 check("x0_ptr_grant", req_ready, 3'b100);
    cycle();

    // Freeze, then clear coinciding with contention
    wb_en = 1'b0;
    req_valid = 3'b011;
    saved = m_cnt;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("freeze_ready", req_ready, 0);
      check("freeze_we", rf_we, 0);
    end
    check("freeze_cnt", cont_cnt, saved);
    wb_en = 1'b1;
    cont_clr = 1'b1;
    cycle();
    check("clr_cnt", cont_cnt, 0);
    cont_clr = 1'b0;

    // Asynchronous reset in the middle of operation
    req_valid = 3'b001;
    a_addr[0] = 5'd7;
    cycle();
    check("pre_rst_we", rf_we, 1);
    req_valid = 3'b000;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_we", rf_we, 0);
    check("async_rst_cnt", cont_cnt, 0);
    check("async_rst_pend", pend_mask, 0);
    #1 rst_n = 1'b1;
    req_valid = 3'b110;
    #1 check("post_rst_grant", req_ready, 3'b010);
    cycle();

    // Saturation of the narrow counter
    req_valid = 3'b111;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_cnt4", cont_cnt4, 15);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      wb_en     = ($urandom_range(0, 9) != 0);
      cont_clr  = ($urandom_range(0, 29) == 0);
      req_valid = NREQ'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        a_addr[i] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
        a_data[i] = $urandom;
      end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
